// File: rtl/adc128s_model.sv
// adc128s_model: SPI slave model of an 8-channel 12-bit ADC with pipelined channel addressing.
module adc128s_model #(
    parameter logic [2:0] RESET_CH = 3'd0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] ana_in,
    output logic        frm_done,
    output logic [2:0]  cur_ch
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0]  ss_q, sclk_q;
    logic [1:0]  mosi_q;
    logic        rel, armed;
    logic [15:0] tx;
    logic [13:0] rx;
    logic [4:0]  cnt;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall, start;
    logic [11:0] ch_val;
    assign ss_fall   = ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign start     = (state == IDLE) & armed & ss_fall;
    assign ch_val    = ana_in[12*cur_ch +: 12];
    assign MISO      = (state != IDLE) & tx[15];
    // a frame may only start after SS_n has been seen high once the synchronizer holds real pin samples
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ss_q     <= 3'b111;
            sclk_q   <= 3'b111;
            mosi_q   <= 2'b00;
            rel      <= 1'b0;
            armed    <= 1'b0;
            state    <= IDLE;
            tx       <= '0;
            rx       <= '0;
            cnt      <= '0;
            cur_ch   <= RESET_CH;
            frm_done <= 1'b0;
        end else begin
            ss_q     <= {ss_q[1:0], SS_n};
            sclk_q   <= {sclk_q[1:0], SCLK};
            mosi_q   <= {mosi_q[0], MOSI};
            rel      <= 1'b1;
            armed    <= armed | (rel & (&ss_q));
            state    <= state_nxt;
            frm_done <= (state == DONE) & ss_rise;
            if (start) begin
                tx  <= {4'b0000, ch_val};
                cnt <= '0;
            end else if (state == SHIFT && !ss_rise) begin
                if (sclk_rise) begin
                    rx  <= {rx[12:0], mosi_q[1]};
                    cnt <= cnt + 5'd1;
                end else if (sclk_fall && cnt != 5'd0) begin
                    tx <= {tx[14:0], 1'b0};
                end
            end
            if (state == DONE && ss_rise) cur_ch <= rx[13:11];
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? SHIFT : IDLE;
            SHIFT:   state_nxt = ss_rise ? IDLE : (sclk_rise && cnt == 5'd15) ? DONE : SHIFT;
            DONE:    state_nxt = ss_rise ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc128s_model.sv
// tb_adc128s_model: randomized SPI frames checked against a frame-level model of the ADC.
module tb_adc128s_model;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        frm_done;
    logic [2:0]  cur_ch;
    logic [95:0] ana_in;
    logic [11:0] chv [8];
    logic [2:0]  m_ch;
    int          done_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    assign ana_in = {chv[7], chv[6], chv[5], chv[4], chv[3], chv[2], chv[1], chv[0]};

    adc128s_model dut (
        .clk(clk), .RST(RST), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .ana_in(ana_in), .frm_done(frm_done), .cur_ch(cur_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (frm_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic d);
        SCLK = 1'b0;
        MOSI = d;
        #50;
        SCLK = 1'b1;
        #50;
    endtask

    // One SPI frame of npulse SCLK pulses; optionally rewrites a channel after chg_at pulses.
    task automatic run_frame(input logic [15:0] word, input int npulse, input int chg_at,
                             input logic [2:0] chg_ch, input logic [11:0] chg_val);
        logic [15:0] exp_tx, got;
        int d0, n;
        check("cur_ch_pre", 32'(cur_ch), 32'(m_ch));
        exp_tx = {4'b0000, chv[m_ch]};
        d0 = done_cnt;
        got = '0;
        SS_n = 1'b0;
        #50;
        for (int i = 0; i < npulse; i++) begin
            if (i == chg_at) chv[chg_ch] = chg_val;
            SCLK = 1'b0;
            MOSI = (i < 16) ? word[15-i] : 1'b0;
            #50;
            if (i < 16) got[15-i] = MISO;
            else check("miso_tail", 32'(MISO), 32'd0);
            SCLK = 1'b1;
            #50;
        end
        SS_n = 1'b1;
        #80;
        n = (npulse < 16) ? npulse : 16;
        check("miso_bits", 32'(got >> (16 - n)), 32'(exp_tx >> (16 - n)));
        if (npulse >= 16) begin
            m_ch = word[13:11];
            check("frm_done", done_cnt - d0, 1);
        end else begin
            check("no_done", done_cnt - d0, 0);
        end
        check("cur_ch", 32'(cur_ch), 32'(m_ch));
        check("miso_idle", 32'(MISO), 32'd0);
    endtask

    function automatic logic [15:0] addr_word(input logic [2:0] a);
        return {2'b00, a, 11'd0};
    endfunction

    initial begin
        logic [15:0] w;
        int np, d0;
        for (int i = 0; i < 8; i++) chv[i] = 12'($urandom);
        chv[0] = 12'hA5C;
        m_ch = 3'd0;
        @(negedge clk);
        #30;
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_done", 32'(frm_done), 32'd0);
        check("rst_ch", 32'(cur_ch), 32'd0);
        RST = 1'b0;
        #50;
        run_frame(addr_word(3'd2), 16, -1, 3'd0, 12'd0);
        chv[2] = 12'h3FF;
        run_frame(addr_word(3'd1), 16, -1, 3'd0, 12'd0);
        chv[1] = 12'h800;
        run_frame(addr_word(3'd1), 16, -1, 3'd0, 12'd0);
        chv[1] = 12'h111;
        run_frame(addr_word(3'd1), 16, 6, 3'd1, 12'h222);
        run_frame(addr_word(3'd4), 9, -1, 3'd0, 12'd0);
        run_frame(addr_word(3'd5), 16, -1, 3'd0, 12'd0);
        chv[m_ch] = chv[m_ch] & 12'hFFE;
        run_frame(16'hFFFF & addr_word(3'd6) | 16'h07FF, 20, -1, 3'd0, 12'd0);
        for (int k = 0; k < 12; k++) begin
            chv[$urandom_range(7)] = 12'($urandom);
            w = 16'($urandom);
            np = ($urandom_range(3) == 0) ? int'($urandom_range(15, 1)) : 16;
            run_frame(w, np, -1, 3'd0, 12'd0);
        end
        chv[0] = 12'hFFF;
        SS_n = 1'b0;
        #50;
        for (int i = 0; i < 7; i++) pulse(1'b1);
        RST = 1'b1;
        #30;
        check("midrst_miso", 32'(MISO), 32'd0);
        check("midrst_ch", 32'(cur_ch), 32'd0);
        RST = 1'b0;
        m_ch = 3'd0;
        #50;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1);
            check("postrst_quiet", 32'(MISO), 32'd0);
        end
        SS_n = 1'b1;
        #80;
        check("postrst_done", done_cnt - d0, 0);
        check("postrst_ch", 32'(cur_ch), 32'd0);
        run_frame(addr_word(3'd3), 16, -1, 3'd0, 12'd0);
        run_frame(addr_word(3'd7), 16, -1, 3'd0, 12'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
